// File: rtl/encrypt_sched.sv
// Round-robin owner scheduler for a shared encrypt engine and its memory bank.
// Optional engine watchdog enabled by defining ENC_WDOG_EN.
module encrypt_sched #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int WDOG_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rdy,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] cmpl,
  output logic [1:0]      eng_start,
  input  logic [2:0]      eng_stop,
  output logic            eng_reset_n,
  output logic            busy,
  output logic [IDW-1:0]  cur_id,
  output logic            err
);

  // state | meaning
  // IDLE  | no owner, arbitrating from ptr
  // GRANT | owner holds bank, loading operands until rdy
  // START | eng_start=01, waiting for engine ack
  // RUN   | engine running, waiting for done
  // DONE  | result readable, waiting for owner to drop req
  typedef enum logic [2:0] {IDLE, GRANT, START, RUN, DONE} state_t;

  localparam logic [2:0] STOP_ACK  = 3'b001;
  localparam logic [2:0] STOP_DONE = 3'b010;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, ptr_nx, cur_id_nx, win_id, id_inc, kid;
  logic            win_vld;
  logic [NREQ-1:0] gnt_nx, cmpl_nx;
  logic [1:0]      eng_start_nx;
  logic            err_nx, eng_reset_n_nx;

`ifdef ENC_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt, wdog_cnt_nx;
  logic           rst_hold, rst_hold_nx;
  logic           timeout;

  assign timeout = ((state == START) || (state == RUN)) && (wdog_cnt == '0);
`endif

  // Rotating priority: scan downwards so the smallest offset from ptr wins last.
  always_comb begin
    int k;
    win_vld = 1'b0;
    win_id  = ptr;
    kid     = '0;
    k       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      kid = IDW'(k);
      if (req[kid]) begin
        win_vld = 1'b1;
        win_id  = kid;
      end
    end
  end

  assign id_inc = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;

  always_comb begin
    state_nx       = state;
    ptr_nx         = ptr;
    cur_id_nx      = cur_id;
    gnt_nx         = gnt;
    cmpl_nx        = '0;
    eng_start_nx   = eng_start;
    err_nx         = 1'b0;
    eng_reset_n_nx = 1'b1;
`ifdef ENC_WDOG_EN
    wdog_cnt_nx = wdog_cnt;
    rst_hold_nx = 1'b0;
    if (rst_hold) eng_reset_n_nx = 1'b0;
    if ((state == START) || (state == RUN)) wdog_cnt_nx = wdog_cnt - 1'b1;
`endif
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nx  = GRANT;
          cur_id_nx = win_id;
          gnt_nx    = NREQ'(1) << win_id;
        end
      end
      GRANT: begin
        if (!req[cur_id]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          ptr_nx   = id_inc;
        end else if (rdy[cur_id]) begin
          state_nx     = START;
          eng_start_nx = 2'b01;
`ifdef ENC_WDOG_EN
          wdog_cnt_nx  = WDW'(WDOG_CYCLES - 1);
`endif
        end
      end
      START: begin
        // a done code still present from the previous job is not an ack
        if (eng_stop == STOP_ACK) begin
          eng_start_nx = 2'b00;
          state_nx     = RUN;
        end
      end
      RUN: begin
        if (eng_stop == STOP_DONE) begin
          cmpl_nx  = NREQ'(1) << cur_id;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!req[cur_id]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          ptr_nx   = id_inc;
        end
      end
      default: begin
        state_nx     = IDLE;
        gnt_nx       = '0;
        eng_start_nx = 2'b00;
      end
    endcase
`ifdef ENC_WDOG_EN
    if (timeout) begin
      state_nx       = DONE;
      eng_start_nx   = 2'b00;
      cmpl_nx        = '0;
      err_nx         = 1'b1;
      eng_reset_n_nx = 1'b0;
      rst_hold_nx    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cur_id      <= '0;
      gnt         <= '0;
      cmpl        <= '0;
      eng_start   <= 2'b00;
      eng_reset_n <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      cur_id      <= cur_id_nx;
      gnt         <= gnt_nx;
      cmpl        <= cmpl_nx;
      eng_start   <= eng_start_nx;
      eng_reset_n <= eng_reset_n_nx;
      busy        <= (state_nx != IDLE);
      err         <= err_nx;
    end
  end

`ifdef ENC_WDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
      rst_hold <= 1'b0;
    end else begin
      wdog_cnt <= wdog_cnt_nx;
      rst_hold <= rst_hold_nx;
    end
  end
`endif

endmodule

// File: tb/tb_encrypt_sched.sv
// Bench for encrypt_sched: engine model, grant/completion scoreboard, scenario tasks.
module tb_encrypt_sched;
  localparam int WDOG = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, rdy, gnt, cmpl;
  logic [1:0] eng_start;
  logic [2:0] eng_stop;
  logic       eng_reset_n, busy, err;
  logic [1:0] cur_id;

  int checks = 0, errors = 0, cmpl_seen = 0;
  int exp_gnt[$];
  int exp_cmpl[$];
  int ack_dly = 1, done_dly = 8;
  bit hang = 1'b0, sticky = 1'b0;
  int em, ecnt;

  always #5 clk = ~clk;

  encrypt_sched #(.NREQ(4), .IDW(2), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .req(req), .rdy(rdy), .gnt(gnt), .cmpl(cmpl),
    .eng_start(eng_start), .eng_stop(eng_stop), .eng_reset_n(eng_reset_n),
    .busy(busy), .cur_id(cur_id), .err(err)
  );

  // Engine model: ack ack_dly cycles after start, done done_dly cycles after ack.
  initial begin
    eng_stop = 3'b000; em = 0; ecnt = 0;
    forever begin
      @(negedge clk);
      if (!reset || !eng_reset_n) begin
        em = 0; eng_stop = 3'b000;
      end else begin
        case (em)
          0: if (eng_start == 2'b01) begin ecnt = ack_dly; em = 1; end
          1: begin
            ecnt--;
            if (ecnt <= 0) begin eng_stop = 3'b001; ecnt = done_dly; em = 2; end
          end
          2: begin
            eng_stop = 3'b000; ecnt--;
            if (ecnt <= 0) begin
              if (hang) em = 0;
              else begin eng_stop = 3'b010; em = 3; end
            end
          end
          default: begin
            if (!sticky) eng_stop = 3'b000;
            em = 0;
          end
        endcase
      end
    end
  end

  // Scoreboard monitor plus structural invariants
  initial begin
    logic [3:0] pg, pc, oh;
    int e;
    pg = '0; pc = '0;
    forever begin
      @(negedge clk);
      if (pg == 4'b0 && gnt != 4'b0) begin
        checks++;
        if (exp_gnt.size() == 0) begin
          errors++; $display("FAIL sb_gnt: got %b expected no grant", gnt);
        end else begin
          e = exp_gnt.pop_front(); oh = 4'b0001 << e;
          if (gnt !== oh) begin errors++; $display("FAIL sb_gnt: got %b expected %b", gnt, oh); end
        end
      end
      if (cmpl != 4'b0) begin
        checks++; cmpl_seen++;
        if (pc != 4'b0) begin errors++; $display("FAIL cmpl_width: got %b after %b expected single pulse", cmpl, pc); end
        if (exp_cmpl.size() == 0) begin
          errors++; $display("FAIL sb_cmpl: got %b expected no completion", cmpl);
        end else begin
          e = exp_cmpl.pop_front(); oh = 4'b0001 << e;
          if (cmpl !== oh) begin errors++; $display("FAIL sb_cmpl: got %b expected %b", cmpl, oh); end
        end
      end
      checks++;
      if (!$onehot0(gnt) || (eng_start == 2'b01 && gnt == 4'b0)) begin
        errors++; $display("FAIL invariant: got gnt=%b eng_start=%b expected one-hot owner while starting", gnt, eng_start);
      end
      pg = gnt; pc = cmpl;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200000ns");
    $fatal(1, "timeout");
  end

  task automatic wait_gnt(input int lim, output int waited);
    waited = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin waited = i; break; end
    end
  endtask

  task automatic wait_cmpl(input int c0, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (cmpl_seen > c0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0; req = '0; rdy = '0;
    exp_gnt.delete(); exp_cmpl.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 7;
    if (gnt !== 4'b0)         begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    if (cmpl !== 4'b0)        begin errors++; $display("FAIL rst_cmpl: got %b expected 0000", cmpl); end
    if (eng_start !== 2'b00)  begin errors++; $display("FAIL rst_eng_start: got %b expected 00", eng_start); end
    if (eng_reset_n !== 1'b1) begin errors++; $display("FAIL rst_eng_reset_n: got %b expected 1", eng_reset_n); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (cur_id !== 2'd0)      begin errors++; $display("FAIL rst_cur_id: got %0d expected 0", cur_id); end
    if (err !== 1'b0)         begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    int n, c0;
    ack_dly = 1; done_dly = 8; hang = 0; sticky = 0;
    exp_gnt.push_back(0);
    req = 4'b0001;
    @(negedge clk);
    checks += 3;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_latency: got %b expected 0001", gnt); end
    if (busy !== 1'b1)   begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    if (cur_id !== 2'd0) begin errors++; $display("FAIL single_cur_id: got %0d expected 0", cur_id); end
    repeat (2) @(negedge clk);
    rdy = 4'b0001; exp_cmpl.push_back(0); c0 = cmpl_seen; n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eng_start == 2'b01) n++;
    end
    checks += 3;
    if (n != ack_dly + 1)       begin errors++; $display("FAIL single_start_cycles: got %0d expected %0d", n, ack_dly + 1); end
    if (cmpl_seen != c0 + 1)    begin errors++; $display("FAIL single_cmpl_count: got %0d expected %0d", cmpl_seen - c0, 1); end
    if (gnt !== 4'b0001)        begin errors++; $display("FAIL single_done_hold: got %b expected 0001", gnt); end
    req = '0; rdy = '0;
    @(negedge clk);
    checks += 3;
    if (gnt !== 4'b0)    begin errors++; $display("FAIL single_release: got %b expected 0000", gnt); end
    if (busy !== 1'b0)   begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    if (cur_id !== 2'd0) begin errors++; $display("FAIL single_hold_id: got %0d expected 0", cur_id); end
  endtask

  task automatic test_contention;
    int w, id, c0;
    bit ok;
    do_reset();
    exp_gnt = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(10, w);
      checks++;
      if (w != 1) begin errors++; $display("FAIL cont_gnt_gap: job %0d got %0d cycles expected 1", j, w); end
      if (w < 0) break;
      id = 0;
      for (int b = 0; b < 4; b++) if (gnt[b]) id = b;
      rdy[id] = 1'b1; exp_cmpl.push_back(id); c0 = cmpl_seen;
      wait_cmpl(c0, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cont_cmpl_timeout: job %0d got none expected cmpl", j); end
      @(negedge clk);
      req[id] = 1'b0; rdy[id] = 1'b0;
      if (j == 4) req = '0;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0) begin errors++; $display("FAIL cont_idle_gap: job %0d got %b expected 0000", j, gnt); end
      if (j < 4) req[id] = 1'b1;
    end
  endtask

  task automatic test_abort;
    int w, c0;
    c0 = cmpl_seen;
    exp_gnt.push_back(2); exp_gnt.push_back(3);
    req = 4'b1100;
    wait_gnt(10, w);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_first: got %b expected 0100", gnt); end
    req[2] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (gnt !== 4'b0)         begin errors++; $display("FAIL abort_release: got %b expected 0000", gnt); end
    if (eng_start !== 2'b00)  begin errors++; $display("FAIL abort_start: got %b expected 00", eng_start); end
    wait_gnt(10, w);
    checks += 2;
    if (gnt !== 4'b1000)     begin errors++; $display("FAIL abort_next: got %b expected 1000", gnt); end
    if (eng_start !== 2'b00) begin errors++; $display("FAIL abort_next_start: got %b expected 00", eng_start); end
    req = '0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (gnt !== 4'b0)     begin errors++; $display("FAIL abort_final: got %b expected 0000", gnt); end
    if (cmpl_seen != c0)  begin errors++; $display("FAIL abort_no_cmpl: got %0d expected 0", cmpl_seen - c0); end
  endtask

  task automatic test_stale_done;
    int w, c0, n, first;
    bit ok;
    do_reset();
    sticky = 1; ack_dly = 1;
    exp_gnt.push_back(1);
    req = 4'b0010;
    wait_gnt(10, w);
    rdy = 4'b0010; exp_cmpl.push_back(1); c0 = cmpl_seen;
    wait_cmpl(c0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stale_first_job: got none expected cmpl"); end
    req = '0; rdy = '0;
    @(negedge clk);
    ack_dly = 6;
    exp_gnt.push_back(1);
    req = 4'b0010;
    wait_gnt(10, w);
    rdy = 4'b0010; exp_cmpl.push_back(1); c0 = cmpl_seen; n = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (eng_start == 2'b01) n++;
      if (cmpl != 4'b0 && first < 0) first = i;
    end
    checks += 2;
    if (n != ack_dly + 1) begin errors++; $display("FAIL stale_start_hold: got %0d expected %0d", n, ack_dly + 1); end
    if (first != ack_dly + done_dly + 1) begin
      errors++; $display("FAIL stale_cmpl_time: got %0d expected %0d", first, ack_dly + done_dly + 1);
    end
    sticky = 0; ack_dly = 1;
    do_reset();
  endtask

  task automatic test_reset_mid_run;
    int w, c0;
    bit ok;
    exp_gnt.push_back(2);
    req = 4'b0100;
    wait_gnt(10, w);
    req = '0;
    @(negedge clk);
    exp_gnt.push_back(3);
    req = 4'b1000;
    wait_gnt(10, w);
    rdy = 4'b1000; exp_cmpl.push_back(3);
    repeat (5) @(negedge clk);
    checks += 2;
    if (eng_start !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_run_state: got start=%b busy=%b expected 00/1", eng_start, busy);
    end
    if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_run_gnt: got %b expected 1000", gnt); end
    #2 reset = 1'b0; req = '0; rdy = '0; exp_cmpl.delete();
    #1;
    checks += 3;
    if (gnt !== 4'b0 || cmpl !== 4'b0 || eng_start !== 2'b00) begin
      errors++; $display("FAIL mid_rst_outs: got gnt=%b cmpl=%b start=%b expected 0000/0000/00", gnt, cmpl, eng_start);
    end
    if (busy !== 1'b0 || cur_id !== 2'd0) begin
      errors++; $display("FAIL mid_rst_busy_id: got busy=%b id=%0d expected 0/0", busy, cur_id);
    end
    if (err !== 1'b0 || eng_reset_n !== 1'b1) begin
      errors++; $display("FAIL mid_rst_err: got err=%b rn=%b expected 0/1", err, eng_reset_n);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    exp_gnt.push_back(1);
    req = 4'b1010;
    wait_gnt(10, w);
    checks++;
    if (cur_id !== 2'd1) begin errors++; $display("FAIL post_rst_ptr: got %0d expected 1", cur_id); end
    rdy = 4'b0010; exp_cmpl.push_back(1); c0 = cmpl_seen;
    wait_cmpl(c0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_rst_cmpl: got none expected cmpl"); end
    req = '0; rdy = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0) begin errors++; $display("FAIL post_rst_release: got %b expected 0000", gnt); end
  endtask

`ifdef ENC_WDOG_EN
  task automatic test_wdog;
    int w, c0;
    bit exp_err, exp_rn;
    do_reset();
    hang = 1;
    exp_gnt.push_back(0);
    req = 4'b0001;
    wait_gnt(10, w);
    rdy = 4'b0001; c0 = cmpl_seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eng_start == 2'b01) break;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_err = (k == WDOG);
      exp_rn  = !((k == WDOG) || (k == WDOG + 1));
      checks += 2;
      if (err !== exp_err)     begin errors++; $display("FAIL wdog_err: cycle %0d got %b expected %b", k, err, exp_err); end
      if (eng_reset_n !== exp_rn) begin errors++; $display("FAIL wdog_rn: cycle %0d got %b expected %b", k, eng_reset_n, exp_rn); end
    end
    checks += 3;
    if (cmpl_seen != c0)     begin errors++; $display("FAIL wdog_no_cmpl: got %0d expected 0", cmpl_seen - c0); end
    if (gnt !== 4'b0001)     begin errors++; $display("FAIL wdog_hold: got %b expected 0001", gnt); end
    if (eng_start !== 2'b00) begin errors++; $display("FAIL wdog_start: got %b expected 00", eng_start); end
    req = '0; rdy = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0) begin errors++; $display("FAIL wdog_release: got %b expected 0000", gnt); end
    hang = 0;
  endtask
`else
  task automatic test_wdog_off;
    int w, c0;
    do_reset();
    hang = 1;
    exp_gnt.push_back(0);
    req = 4'b0001;
    wait_gnt(10, w);
    rdy = 4'b0001; c0 = cmpl_seen;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || eng_reset_n !== 1'b1) begin
        errors++; $display("FAIL nowdog_outs: got err=%b rn=%b expected 0/1", err, eng_reset_n);
      end
    end
    checks += 2;
    if (busy !== 1'b1 || gnt !== 4'b0001) begin
      errors++; $display("FAIL nowdog_wait: got busy=%b gnt=%b expected 1/0001", busy, gnt);
    end
    if (cmpl_seen != c0) begin errors++; $display("FAIL nowdog_no_cmpl: got %0d expected 0", cmpl_seen - c0); end
    hang = 0;
    do_reset();
  endtask
`endif

  initial begin
    reset = 1'b0; req = '0; rdy = '0;
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_stale_done();
    test_reset_mid_run();
`ifdef ENC_WDOG_EN
    test_wdog();
`else
    test_wdog_off();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_gnt.size() != 0 || exp_cmpl.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", exp_gnt.size(), exp_cmpl.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
